stack_port_ctrl: RTL and testbench

STACK_PORT_CTRL -- requirements
Module: stack_port_ctrl

---
 rtl/stack_port_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stack_port_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_port_ctrl.sv
// Command/response front end for an external stack with a shared data bus.
// Optional sticky error flag: define STACK_PORT_ERR_STICKY_EN.
module stack_port_ctrl #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Cmd_Valid,
    input  logic               Cmd_Push,
    input  logic [DATA_W-1:0]  Cmd_Data,
    output logic               Cmd_Ready,
    output logic               Rsp_Valid,
    output logic [DATA_W-1:0]  Rsp_Data,
    output logic               Rsp_Err,
    input  logic               Rsp_Ready,
    inout  wire  [DATA_W-1:0]  Stk_IO,
    output logic               Stk_Push_Pop,
    output logic               Stk_Enable,
    input  logic               Stk_Full,
    input  logic               Stk_Empty,
    output logic [DEPTH_W-1:0] Count
`ifdef STACK_PORT_ERR_STICKY_EN
    ,
    output logic               Err_Sticky
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_REQ,
        POP_CAP,
        RESP
    } state_t;

    localparam logic [DEPTH_W-1:0] CNT_MAX = {DEPTH_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nx;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [DEPTH_W-1:0]  r_count;
    logic                r_live;
    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_push_ok;
    logic                w_pop_ok;
    logic                w_reject;
    logic                w_stk_en;
    logic                w_stk_pp;

    // Either status source reporting full/empty blocks the operation.
    assign w_push_ok   = !Stk_Full && (r_count != CNT_MAX);
    assign w_pop_ok    = !Stk_Empty && (r_count != '0);
    assign w_cmd_ready = r_live && (r_state == IDLE);
    assign w_accept    = Cmd_Valid && w_cmd_ready;
    assign w_reject    = w_accept && (Cmd_Push ? !w_push_ok : !w_pop_ok);

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and stack strobe decode.
    always_comb begin
        w_state_nx = r_state;
        w_stk_en   = 1'b0;
        w_stk_pp   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        w_state_nx = RESP;
                    end else if (Cmd_Push) begin
                        w_state_nx = PUSH;
                    end else begin
                        w_state_nx = POP_REQ;
                    end
                end
            end
            PUSH: begin
                w_stk_en   = 1'b1;
                w_stk_pp   = 1'b1;
                w_state_nx = RESP;
            end
            POP_REQ: begin
                w_stk_en   = 1'b1;
                w_state_nx = POP_CAP;
            end
            POP_CAP: begin
                w_stk_en   = 1'b1;
                w_state_nx = RESP;
            end
            RESP: begin
                if (Rsp_Ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Datapath: latched push data, occupancy count and response fields.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_live     <= 1'b0;
            r_data     <= '0;
            r_count    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_rsp_data <= '0;
                r_rsp_err  <= w_reject;
                if (Cmd_Push) begin
                    r_data <= Cmd_Data;
                end
            end
            if (r_state == PUSH) begin
                r_count <= r_count + 1'b1;
            end
            if (r_state == POP_REQ) begin
                r_count <= r_count - 1'b1;
            end
            if (r_state == POP_CAP) begin
                r_rsp_data <= Stk_IO;
            end
        end
    end

`ifdef STACK_PORT_ERR_STICKY_EN
    logic r_err_sticky;

    // Remembers any rejected command until the next reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_err_sticky <= 1'b0;
        end else if (w_reject) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign Err_Sticky = r_err_sticky;
`endif

    assign Stk_IO       = (r_state == PUSH) ? r_data : {DATA_W{1'bz}};
    assign Stk_Enable   = w_stk_en;
    assign Stk_Push_Pop = w_stk_pp;
    assign Cmd_Ready    = w_cmd_ready;
    assign Rsp_Valid    = (r_state == RESP);
    assign Rsp_Data     = r_rsp_data;
    assign Rsp_Err      = r_rsp_err;
    assign Count        = r_count;

endmodule

// File: tb/tb_stack_port_ctrl.sv
// Scoreboard bench for stack_port_ctrl with a behavioural stack model.
// Define STACK_PORT_ERR_STICKY_EN to also check the sticky error flag.
module tb_stack_port_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_push = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_ready = 1'b1;
    wire  [7:0] stk_io;
    logic       stk_pp;
    logic       stk_en;
    logic       stk_full;
    logic       stk_empty;
    logic [9:0] count;
`ifdef STACK_PORT_ERR_STICKY_EN
    logic       err_sticky;
`endif

    logic       force_full = 1'b0;
    logic       force_empty = 1'b0;
    logic [7:0] mem [0:31];
    int         sp;
    logic [7:0] drv;
    logic       oe;
    logic       popping;
    int         cyc = 0;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit         push;
        logic       err;
        logic [7:0] data;
        int         lat;
        int         en;
        logic [7:0] io;
        logic [9:0] cnt;
        int         acc;
    } exp_t;

    exp_t q[$];

    stack_port_ctrl #(.DATA_W(8), .DEPTH_W(10)) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .Cmd_Valid    (cmd_valid),
        .Cmd_Push     (cmd_push),
        .Cmd_Data     (cmd_data),
        .Cmd_Ready    (cmd_ready),
        .Rsp_Valid    (rsp_valid),
        .Rsp_Data     (rsp_data),
        .Rsp_Err      (rsp_err),
        .Rsp_Ready    (rsp_ready),
        .Stk_IO       (stk_io),
        .Stk_Push_Pop (stk_pp),
        .Stk_Enable   (stk_en),
        .Stk_Full     (stk_full),
        .Stk_Empty    (stk_empty),
        .Count        (count)
`ifdef STACK_PORT_ERR_STICKY_EN
        ,
        .Err_Sticky   (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign stk_io    = oe ? drv : 8'hzz;
    assign stk_full  = force_full || (sp == 16);
    assign stk_empty = force_empty || (sp == 0);

    // Stack model: first pop strobe removes the top, bus driven next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= 0;
            oe      <= 1'b0;
            popping <= 1'b0;
            drv     <= 8'h00;
        end else if (stk_en && stk_pp) begin
            mem[sp] <= stk_io;
            sp      <= sp + 1;
        end else if (stk_en && !popping) begin
            drv     <= mem[sp-1];
            sp      <= sp - 1;
            oe      <= 1'b1;
            popping <= 1'b1;
        end else if (stk_en) begin
            oe      <= 1'b0;
            popping <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: strobe accounting, response checking, hold stability.
    int         en_cnt = 0;
    int         push_cnt = 0;
    logic [7:0] last_io = 8'h00;
    logic       prev_valid = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_err = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            en_cnt     = 0;
            push_cnt   = 0;
            prev_valid = 1'b0;
        end else begin
            check("pp_without_en", {31'd0, stk_pp && !stk_en}, 32'd0);
            if (stk_en) begin
                en_cnt++;
                if (stk_pp) begin
                    push_cnt++;
                    last_io = stk_io;
                end
            end
            if (rsp_valid && !prev_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                    check("latency", cyc - e.acc + 1, e.lat);
                    check("strobes", en_cnt, e.en);
                    check("push_strobes", push_cnt, e.push && e.en > 0 ? 1 : 0);
                    check("count", {22'd0, count}, {22'd0, e.cnt});
                    check("cmd_ready_in_rsp", {31'd0, cmd_ready}, 32'd0);
                    if (e.push && e.en > 0)
                        check("push_io", {24'd0, last_io}, {24'd0, e.io});
                end
                en_cnt    = 0;
                push_cnt  = 0;
                hold_data = rsp_data;
                hold_err  = rsp_err;
            end else if (rsp_valid) begin
                check("hold_data", {24'd0, rsp_data}, {24'd0, hold_data});
                check("hold_err", {31'd0, rsp_err}, {31'd0, hold_err});
                check("cmd_ready_hold", {31'd0, cmd_ready}, 32'd0);
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic wait_ready(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        ok = cmd_ready;
        if (!ok) check("cmd_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic cmd(input bit push, input logic [7:0] d,
                       input logic err, input logic [7:0] rd,
                       input int lat, input int en, input logic [9:0] cnt);
        exp_t e;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        e.push = push;
        e.err  = err;
        e.data = rd;
        e.lat  = lat;
        e.en   = en;
        e.io   = d;
        e.cnt  = cnt;
        e.acc  = cyc + 1;
        q.push_back(e);
        cmd_valid = 1'b1;
        cmd_push  = push;
        cmd_data  = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    initial begin
        bit ok;
        int t;
        #2;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_stk_en", {31'd0, stk_en}, 32'd0);
        check("rst_count", {22'd0, count}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        cmd(1, 8'hA5, 0, 8'h00, 2, 1, 10'd1);
        cmd(0, 8'h00, 0, 8'hA5, 3, 2, 10'd0);
        cmd(1, 8'h11, 0, 8'h00, 2, 1, 10'd1);
        cmd(1, 8'h22, 0, 8'h00, 2, 1, 10'd2);
        cmd(0, 8'h00, 0, 8'h22, 3, 2, 10'd1);
        cmd(0, 8'h00, 0, 8'h11, 3, 2, 10'd0);
        cmd(0, 8'h00, 1, 8'h00, 1, 0, 10'd0);

        wait_ready(ok);
        force_full = 1'b1;
        cmd(1, 8'h33, 1, 8'h00, 1, 0, 10'd0);
        wait_ready(ok);
        force_full = 1'b0;

        rsp_ready = 1'b0;
        cmd(1, 8'h44, 0, 8'h00, 2, 1, 10'd1);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        repeat (5) @(negedge clk);
        check("held_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_released", {31'd0, rsp_valid}, 32'd0);
        check("idle_ready", {31'd0, cmd_ready}, 32'd1);
        cmd(0, 8'h00, 0, 8'h44, 3, 2, 10'd0);

        cmd(1, 8'h77, 0, 8'h00, 2, 1, 10'd1);
        wait_ready(ok);
        if (ok) begin
            cmd_valid = 1'b1;
            cmd_push  = 1'b0;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            check("in_pop_req", {31'd0, stk_en}, 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check("arst_stk_en", {31'd0, stk_en}, 32'd0);
            check("arst_stk_pp", {31'd0, stk_pp}, 32'd0);
            check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("arst_rsp_data", {24'd0, rsp_data}, 32'd0);
            check("arst_rsp_err", {31'd0, rsp_err}, 32'd0);
            check("arst_count", {22'd0, count}, 32'd0);
            check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            check("ready_first_edge", {31'd0, cmd_ready}, 32'd1);
            repeat (5) begin
                @(negedge clk);
                check("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
            end
        end

        cmd(1, 8'h55, 0, 8'h00, 2, 1, 10'd1);
        wait_ready(ok);
        force_empty = 1'b1;
        cmd(0, 8'h00, 1, 8'h00, 1, 0, 10'd1);
        wait_ready(ok);
        force_empty = 1'b0;
        cmd(0, 8'h00, 0, 8'h55, 3, 2, 10'd0);

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("queue_drained", q.size(), 32'd0);
`ifdef STACK_PORT_ERR_STICKY_EN
        check("err_sticky", {31'd0, err_sticky}, 32'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
